wr_ptr_ctrl_param: RTL and testbench

- Write-domain pointer/flag controller for the dual-clock FIFO. Parametrised successor of the fixed 5-bit write pointer controller.
- Owns the write pointer and its Gray copy. Synchronises the read-domain Gray pointer internally.
- Produces registered full, almost_full, fill level and a sticky overflow flag.
- Sits between the write-side client, the dual-port FIFO memory (w_addr, w_inc) and the read pointer controller (w_ptr_gray).

---
 rtl/wr_ptr_ctrl_param.sv | 90 +++++++++
 tb/tb_wr_ptr_ctrl_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wr_ptr_ctrl_param.sv
// Write-domain pointer and flag controller for the dual-clock FIFO.
// Owns the binary/Gray write pointer and synchronises the read-side Gray pointer.
module wr_ptr_ctrl_param #(
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2
) (
    input  logic          w_clk,
    input  logic          w_reset,
    input  logic          w_en,
    input  logic          ovf_clr,
    input  logic [AW:0]   r_ptr_gray,
    output logic [AW-1:0] w_addr,
    output logic          w_inc,
    output logic [AW:0]   w_ptr_gray,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   w_level,
    output logic          overflow
);
    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] AF_THRESH = (AW+1)'(DEPTH - AF_MARGIN);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0]                   w_bin;
    logic [AW:0]                   w_bin_next;
    logic [AW:0]                   w_gray_next;
    logic [SYNC_STAGES-1:0][AW:0]  sync_q;
    logic [AW:0]                   rq_gray;
    logic [AW:0]                   rq_bin;
    logic [AW:0]                   level_next;
    logic                          full_next;

    // Read pointer crossing: plain flop chain, Gray coding keeps each sample within one step.
    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], r_ptr_gray};
        end
    end

    assign rq_gray = sync_q[SYNC_STAGES-1];
    assign rq_bin  = gray2bin(rq_gray);

    assign w_inc       = w_en & ~full;
    assign w_bin_next  = w_bin + {{AW{1'b0}}, w_inc};
    assign w_gray_next = bin2gray(w_bin_next);
    assign level_next  = w_bin_next - rq_bin;
    // Full when the pointers differ only in the wrap bit: top two Gray bits inverted.
    assign full_next   = (w_gray_next == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});

    assign w_addr = w_bin[AW-1:0];

    // Pointer and flag registers; flags see the post-write pointer on the same edge.
    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            w_bin       <= '0;
            w_ptr_gray  <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            overflow    <= 1'b0;
        end else begin
            w_bin       <= w_bin_next;
            w_ptr_gray  <= w_gray_next;
            full        <= full_next;
            almost_full <= (level_next >= AF_THRESH);
            w_level     <= level_next;
            if (w_en & full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wr_ptr_ctrl_param.sv
// Directed plus randomised bench for wr_ptr_ctrl_param, checked against a
// count-based FIFO occupancy model with a delayed view of the read count.
module tb_wr_ptr_ctrl_param;
    localparam int AW    = 4;
    localparam int SYNC  = 2;
    localparam int AFM   = 2;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic          w_clk = 1'b0;
    logic          w_reset = 1'b1;
    logic          w_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   r_ptr_gray = '0;
    logic [AW-1:0] w_addr;
    logic          w_inc;
    logic [AW:0]   w_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [AW:0]   w_level;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    // Model state: total words written and read, as unbounded counts.
    int m_wcnt = 0;
    int r_cnt  = 0;
    int m_level = 0;
    bit m_full = 0;
    bit m_af = 0;
    bit m_ovf = 0;
    int rq_hist[$];

    wr_ptr_ctrl_param #(.AW(AW), .SYNC_STAGES(SYNC), .AF_MARGIN(AFM)) dut (
        .w_clk(w_clk), .w_reset(w_reset), .w_en(w_en), .ovf_clr(ovf_clr),
        .r_ptr_gray(r_ptr_gray), .w_addr(w_addr), .w_inc(w_inc),
        .w_ptr_gray(w_ptr_gray), .full(full), .almost_full(almost_full),
        .w_level(w_level), .overflow(overflow)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    function automatic int gray(input int v);
        int m;
        m = v % PMOD;
        return (m ^ (m >> 1));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0; r_cnt = 0; m_level = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
        rq_hist.delete();
        for (int i = 0; i < SYNC; i++) rq_hist.push_back(0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".w_addr"}, int'(w_addr), m_wcnt % DEPTH);
        check({tag, ".w_ptr_gray"}, int'(w_ptr_gray), gray(m_wcnt));
        check({tag, ".full"}, int'(full), int'(m_full));
        check({tag, ".almost_full"}, int'(almost_full), int'(m_af));
        check({tag, ".w_level"}, int'(w_level), m_level);
        check({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    endtask

    // One w_clk cycle: drive at the falling edge, advance model, check after the rising edge.
    task automatic step(input string tag, input bit we, input bit clr);
        bit inc;
        int rq;
        @(negedge w_clk);
        w_en = we;
        ovf_clr = clr;
        r_ptr_gray = (AW+1)'(gray(r_cnt));
        #1;
        inc = we && !m_full;
        check({tag, ".w_inc"}, int'(w_inc), int'(inc));
        if (we && m_full) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_wcnt += int'(inc);
        rq = rq_hist.pop_front();
        rq_hist.push_back(r_cnt);
        m_level = m_wcnt - rq;
        m_full = (m_level == DEPTH);
        m_af = (m_level >= DEPTH - AFM);
        @(posedge w_clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int edges;
        int guard;
        logic [AW:0] prev_gray;

        model_reset();
        repeat (3) @(posedge w_clk);
        @(negedge w_clk);
        w_reset = 1'b0;
        #1;
        check_outputs("reset");
        step("idle", 0, 0);
        step("idle", 0, 0);

        // Fill 16 slots with the read pointer parked at 0.
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1, 0);
            if (i == 13) check("af_before_14", int'(almost_full), 0);
            if (i == 14) check("af_at_14", int'(almost_full), 1);
            if (i == 15) check("full_before_16", int'(full), 0);
        end
        check("full_at_16", int'(full), 1);
        check("gray_at_16", int'(w_ptr_gray), 24);
        check("addr_wrap", int'(w_addr), 0);
        check("level_16", int'(w_level), 16);

        // Writes while full set the sticky overflow.
        for (int i = 0; i < 3; i++) step("ovf_write", 1, 0);
        check("ovf_sticky", int'(overflow), 1);
        check("ovf_ptr_hold", int'(w_ptr_gray), 24);
        step("ovf_clear", 0, 1);
        check("ovf_cleared", int'(overflow), 0);

        // One read: full must drop exactly three edges after r_ptr_gray changes.
        r_cnt = 1;
        edges = 0;
        guard = 0;
        while (full && guard < 10) begin
            step("read_one", 0, 0);
            edges++;
            guard++;
        end
        check("full_fall_edges", edges, SYNC + 1);
        check("level_15", int'(w_level), 15);
        step("refill", 1, 0);
        check("refull", int'(full), 1);

        // Set overflow, then drain to level 9 for the async reset check.
        step("ovf_again", 1, 0);
        guard = 0;
        while (m_level != 9 && guard < 40) begin
            if (r_cnt < m_wcnt) r_cnt++;
            step("drain", 0, 0);
            guard++;
        end
        check("drain_level9", int'(w_level), 9);
        check("drain_ovf", int'(overflow), 1);

        @(negedge w_clk);
        #2;
        w_reset = 1'b1;
        r_ptr_gray = '0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst.w_inc", int'(w_inc), 0);
        #1;
        w_reset = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst", 1, 0);

        // Streaming: reader trails the writer, pointer crosses the 31->0 wrap.
        prev_gray = w_ptr_gray;
        for (int i = 0; i < 40; i++) begin
            r_cnt = (m_wcnt > 3) ? m_wcnt - 3 : r_cnt;
            step("stream", 1, 0);
            check("stream_level_le6", int'(w_level <= 6), 1);
            check("stream_gray_1bit", $countones(w_ptr_gray ^ prev_gray), 1);
            prev_gray = w_ptr_gray;
        end
        check("stream_wrapped", int'(m_wcnt > PMOD), 1);

        // Random writes, reads and clears against the model.
        for (int i = 0; i < 300; i++) begin
            if (r_cnt < m_wcnt && $urandom_range(0, 2) != 0) r_cnt++;
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
